fp_rnd_pipe: RTL
================

// Module: fp_rnd_pipe
// PURPOSE
//   Final rounding/packing stage of the FP datapath; consumes fp_fma's fp_rnd bundle (biased expo, 24/53-bit mant
//   incl. hidden bit, grs, specials). Produces IEEE-754 single/double result + fflags. 2-stage pipeline, valid/ready.
// PARAMETERS
//   QNAN_S   32'h7FC00000          canonical single NaN
//   QNAN_D   64'h7FF8000000000000  canonical double NaN
// PORTS
//   clock      in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high reset
//   in_valid   in   1   input bundle valid (fp_fma ready)
//   in_ready   out  1   stage can accept
//   sig        in   1   result sign
//   expo       in   14  biased exponent, signed; 0 => subnormal
//   mant       in   54  single: [23:0] used; double: [52:0] used; MSB = hidden bit
//   grs        in   3   guard, round, sticky
//   fmt        in   2   0 single, 1 double; others => treated as double
//   rm         in   3   0 RNE,1 RTZ,2 RDN,3 RUP,4 RMM; 5-7 => RNE
//   snan,qnan,dbz,inf,zero in 1 each  special-case flags
//   out_valid  out  1   result valid
//   out_ready  in   1   consumer accepts
//   result     out  64  packed result; single NaN-boxed (result[63:32]=all ones)
//   flags      out  5   {NV,DZ,OF,UF,NX}
// BEHAVIOUR
// - Reset: out_valid=0, result=0, flags=0, all stage valids 0; in_ready=1 in the reset state. In-flight ops are discarded.
// - Pipeline enable en = ~out_valid | out_ready; in_ready = en; both stages advance only when en=1.
//   Under stall, result/flags/out_valid are held stable. A bubble (in_valid=0) propagates as valid=0.
// - Latency 2 cycles from accepted input to out_valid; throughput 1/cycle.
// - Stage 1 (increment decide), with L = mant LSB and G,R,S = grs:
//   RNE inc = G&(R|S|L); RTZ 0; RDN inc = ~sig&0 | sig&(G|R|S); RUP inc = ~sig&(G|R|S); RMM inc = G.
//   NX0 = |grs.
// - Stage 2 (apply):
//   m' = mant + inc (25/54-bit).
//   Carry out of the hidden position: m' >>= 1, expo += 1.
//   expo==0 and m' hidden bit set: expo = 1 (subnormal rounds up to normal).
//   Overflow when expo >= 255 (S) / 2047 (D): OF=NX=1.
//   Overflow result is inf if rm is RNE/RMM, or RUP&~sig, or RDN&sig; otherwise max finite (7F7FFFFF / 7FEFFFFFFFFFFFFF) with sign.
//   UF = (input expo==0) & NX0 (tininess before rounding).
//   NX = NX0 | OF.
// - Specials, priority snan > qnan > dbz > inf > zero; all override rounding:
//   snan: canonical NaN, NV=1.
//   qnan: canonical NaN, no flags.
//   dbz: inf with sig, DZ=1.
//   inf: inf with sig, no flags.
//   zero: signed zero (sig), flags 0.
// - Exponent arithmetic is 14-bit signed. Negative expo is never delivered by fp_fma and is treated as 0.
// - Back-to-back inputs with out_ready toggling must produce an identical ordered result stream; no drop or duplicate.
// CONFIGURATION
//   FP_RND_FTZ_EN defined: final expo==0 with nonzero mantissa is flushed to signed zero, flags UF|NX set.
//   FP_RND_FTZ_EN undefined: IEEE gradual underflow as above.
// STRUCTURE
//   fp_wire package: fp_rnd_pipe_reg_1/2 types + init constants, rm encoding localparams, flag bit indices, canonical NaN/inf constants.
//   Sub-module fp_rnd_inc: combinational {rm,sig,L,grs} -> inc, instantiated in stage 1.
// TESTING
//   1.0f*: sig0 expo127 mant24'h800000 grs3'b100 L0 RNE -> 3F800000 (tie even, no inc), flags NX.
//   Same but mant24'h800001 RNE -> 3F800002, NX. Same with RTZ -> 3F800001, NX.
//   Double carry: expo1022 mant53'h1FFFFFFFFFFFFF grs3'b111 RUP -> 3FF0000000000000, NX.
//   Overflow: single expo254 mant all ones grs3'b110 RNE -> 7F800000, OF|NX.
//   Overflow with RTZ -> 7F7FFFFF, OF|NX.
//   Specials: snan -> FFFFFFFF7FC00000 (single), NV. dbz sig1 double -> FFF0000000000000, DZ.
//   Stall/reset: 4 back-to-back ops, out_ready low 3 cycles -> results held, order preserved.
//   Reset asserted mid-flight -> out_valid=0 same cycle, no stale output after release.

Source files
------------

// File: rtl/fp_wire.sv
// Shared types and constants for the FP rounding/packing pipeline.
// Rounding modes, flag bit positions, canonical NaN/inf and stage registers.
package fp_wire;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  localparam logic [31:0] CANON_NAN_S = 32'h7FC0_0000;
  localparam logic [63:0] CANON_NAN_D = 64'h7FF8_0000_0000_0000;
  localparam logic [31:0] NAN_BOX     = 32'hFFFF_FFFF;

  localparam logic [30:0] INF_MAG_S  = 31'h7F80_0000;
  localparam logic [30:0] MAXF_MAG_S = 31'h7F7F_FFFF;
  localparam logic [62:0] INF_MAG_D  = 63'h7FF0_0000_0000_0000;
  localparam logic [62:0] MAXF_MAG_D = 63'h7FEF_FFFF_FFFF_FFFF;

  localparam logic [14:0] EMAX_S = 15'd255;
  localparam logic [14:0] EMAX_D = 15'd2047;

  typedef struct packed {
    logic        valid;
    logic        sig;
    logic [13:0] expo;
    logic [53:0] mant;
    logic        dbl;
    logic [2:0]  rm;
    logic        snan;
    logic        qnan;
    logic        dbz;
    logic        inf;
    logic        zero;
    logic        inc;
    logic        nx0;
  } fp_rnd_pipe_reg_1_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] result;
    logic [4:0]  flags;
  } fp_rnd_pipe_reg_2_t;

  localparam fp_rnd_pipe_reg_1_t FP_RND_PIPE_REG_1_INIT = '0;
  localparam fp_rnd_pipe_reg_2_t FP_RND_PIPE_REG_2_INIT = '0;

endpackage

// File: rtl/fp_rnd_inc.sv
// Round-increment decision from rounding mode, sign, LSB and guard bits.
// Unknown modes fall back to round-to-nearest-even.
module fp_rnd_inc
  import fp_wire::*;
(
  input  logic [2:0] rm,
  input  logic       sig,
  input  logic       lsb,
  input  logic [2:0] grs,
  output logic       inc
);

  logic g;
  logic rs;

  assign g  = grs[2];
  assign rs = grs[1] | grs[0];

  // select increment per rounding mode
  always_comb begin
    inc = 1'b0;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sig & (g | rs);
      RM_RUP:  inc = ~sig & (g | rs);
      RM_RMM:  inc = g;
      default: inc = g & (rs | lsb);
    endcase
  end

endmodule

// File: rtl/fp_rnd_pipe.sv
// Two-stage FP round/pack: stage 1 decides increment, stage 2 applies and packs.
// Define FP_RND_FTZ_EN to flush subnormal results to signed zero.
module fp_rnd_pipe
  import fp_wire::*;
#(
  parameter logic [31:0] QNAN_S = CANON_NAN_S,
  parameter logic [63:0] QNAN_D = CANON_NAN_D
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sig,
  input  logic [13:0] expo,
  input  logic [53:0] mant,
  input  logic [2:0]  grs,
  input  logic [1:0]  fmt,
  input  logic [2:0]  rm,
  input  logic        snan,
  input  logic        qnan,
  input  logic        dbz,
  input  logic        inf,
  input  logic        zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic [4:0]  flags
);

  fp_rnd_pipe_reg_1_t r1, n1;
  fp_rnd_pipe_reg_2_t r2, n2;

  logic        en;
  logic        dbl;
  logic [2:0]  rm_c;
  logic        inc;
  logic [54:0] m_sum;
  logic [54:0] m_fin;
  logic        carry;
  logic        hid;
  logic [14:0] e_fin;
  logic        of;
  logic        inf_sel;
  logic [31:0] res_s;
  logic [63:0] res_d;
  logic [4:0]  flg;
  logic        unused_bits;

  assign en        = ~r2.valid | out_ready;
  assign in_ready  = en;
  assign out_valid = r2.valid;
  assign result    = r2.result;
  assign flags     = r2.flags;

  assign dbl  = (fmt != 2'd0);
  assign rm_c = (rm > RM_RMM) ? RM_RNE : rm;

  assign unused_bits = ^{mant[53], m_fin[54:53]};

  fp_rnd_inc u_inc (
    .rm  (rm_c),
    .sig (sig),
    .lsb (mant[0]),
    .grs (grs),
    .inc (inc)
  );

  // stage 1: capture operand, clamp expo, mask mant
  always_comb begin
    n1       = FP_RND_PIPE_REG_1_INIT;
    n1.valid = in_valid;
    n1.sig   = sig;
    n1.expo  = expo[13] ? 14'd0 : expo;
    n1.mant  = dbl ? {1'b0, mant[52:0]}
                   : {30'd0, mant[23:0]};
    n1.dbl   = dbl;
    n1.rm    = rm_c;
    n1.snan  = snan;
    n1.qnan  = qnan;
    n1.dbz   = dbz;
    n1.inf   = inf;
    n1.zero  = zero;
    n1.inc   = inc;
    n1.nx0   = |grs;
  end

  // stage 2: apply increment, renormalise, pack, specials
  always_comb begin
    m_sum   = {1'b0, r1.mant} + 55'(r1.inc);
    carry   = r1.dbl ? m_sum[53] : m_sum[24];
    m_fin   = carry ? (m_sum >> 1) : m_sum;
    hid     = r1.dbl ? m_fin[52] : m_fin[23];
    e_fin   = {1'b0, r1.expo} + 15'(carry);
    if (e_fin == 15'd0 && hid) e_fin = 15'd1;
    of      = e_fin >= (r1.dbl ? EMAX_D : EMAX_S);
    inf_sel = (r1.rm == RM_RNE) | (r1.rm == RM_RMM)
            | ((r1.rm == RM_RUP) & ~r1.sig)
            | ((r1.rm == RM_RDN) & r1.sig);
    res_s   = {r1.sig, e_fin[7:0], m_fin[22:0]};
    res_d   = {r1.sig, e_fin[10:0], m_fin[51:0]};
    if (of) begin
      res_s = {r1.sig, inf_sel ? INF_MAG_S : MAXF_MAG_S};
      res_d = {r1.sig, inf_sel ? INF_MAG_D : MAXF_MAG_D};
    end
    flg         = 5'd0;
    flg[FLG_OF] = of;
    flg[FLG_NX] = r1.nx0 | of;
    flg[FLG_UF] = (r1.expo == 14'd0) & r1.nx0;
`ifdef FP_RND_FTZ_EN
    if (!of && e_fin == 15'd0 && m_fin != 55'd0) begin
      res_s       = {r1.sig, 31'd0};
      res_d       = {r1.sig, 63'd0};
      flg[FLG_UF] = 1'b1;
      flg[FLG_NX] = 1'b1;
    end
`endif
    n2       = FP_RND_PIPE_REG_2_INIT;
    n2.valid = r1.valid;
    priority case (1'b1)
      r1.snan: begin
        n2.result       = r1.dbl ? QNAN_D : {NAN_BOX, QNAN_S};
        n2.flags[FLG_NV] = 1'b1;
      end
      r1.qnan: begin
        n2.result = r1.dbl ? QNAN_D : {NAN_BOX, QNAN_S};
      end
      r1.dbz: begin
        n2.result = r1.dbl ? {r1.sig, INF_MAG_D}
                           : {NAN_BOX, r1.sig, INF_MAG_S};
        n2.flags[FLG_DZ] = 1'b1;
      end
      r1.inf: begin
        n2.result = r1.dbl ? {r1.sig, INF_MAG_D}
                           : {NAN_BOX, r1.sig, INF_MAG_S};
      end
      r1.zero: begin
        n2.result = r1.dbl ? {r1.sig, 63'd0}
                           : {NAN_BOX, r1.sig, 31'd0};
      end
      default: begin
        n2.result = r1.dbl ? res_d : {NAN_BOX, res_s};
        n2.flags  = flg;
      end
    endcase
  end

  // stage 1 register, advances with pipeline enable
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r1 <= FP_RND_PIPE_REG_1_INIT;
    else if (en) r1 <= n1;
  end

  // stage 2 output register, held under stall
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r2 <= FP_RND_PIPE_REG_2_INIT;
    else if (en) r2 <= n2;
  end

endmodule
